// File: rtl/adder_accum.sv
// adder_accum: frame accumulator downstream of the adder.
//   Sums LEN consecutive valid samples into one frame total and presents it
//   on a valid/ready output that is held until consumed.
//   The input side is always ready (no backpressure toward the adder).
//
// Optional feature macro: ADDER_ACCUM_AVG_EN
//   defined   -> sum carries frame total >> $clog2(LEN) (LEN must be 2^n)
//   undefined -> sum carries the raw frame total
//
// Ports:
//   clk        in   clock
//   resetn     in   asynchronous active-low reset
//   valid      in   sample valid (adder valid_out)
//   din        in   [BITS-1:0] sample data (adder o)
//   clear      in   synchronous flush of frame, output valid and overrun
//   sum        out  [OUT_BITS-1:0] frame result
//   sum_valid  out  frame result valid
//   sum_ready  in   consumer accepts sum
//   overrun    out  sticky: an unconsumed result was overwritten
//   frame_pos  out  [$clog2(LEN):0] samples accumulated in current frame
module adder_accum #(
    parameter int unsigned BITS = 32,
    parameter int unsigned LEN  = 4,
    localparam int unsigned OUT_BITS = BITS + $clog2(LEN)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  valid,
    input  logic [BITS-1:0]       din,
    input  logic                  clear,
    output logic [OUT_BITS-1:0]   sum,
    output logic                  sum_valid,
    input  logic                  sum_ready,
    output logic                  overrun,
    output logic [$clog2(LEN):0]  frame_pos
);

    localparam int unsigned LB = $clog2(LEN);
    localparam int unsigned PW = LB + 1;
    localparam logic [PW-1:0] LAST_POS = PW'(LEN - 1);

    if ((LEN < 1) || (LEN > 256)) begin : g_len_range_check
        $error("adder_accum: LEN must be in 1..256");
    end

`ifdef ADDER_ACCUM_AVG_EN
    if ((LEN & (LEN - 1)) != 0) begin : g_len_pow2_check
        $error("adder_accum: LEN must be a power of two when averaging");
    end
`endif

    logic [OUT_BITS-1:0] acc_q, acc_d;
    logic [PW-1:0]       pos_q, pos_d;
    logic [OUT_BITS-1:0] sum_q, sum_d;
    logic                sv_q, sv_d;
    logic                ov_q, ov_d;

    logic [OUT_BITS-1:0] din_ext;
    logic [OUT_BITS-1:0] total;
    logic [OUT_BITS-1:0] result;
    logic                last;
    logic                xfer;

    assign din_ext = OUT_BITS'(din);
    assign total   = acc_q + din_ext;
    assign last    = (pos_q == LAST_POS);
    assign xfer    = sv_q && sum_ready;

`ifdef ADDER_ACCUM_AVG_EN
    assign result = total >> LB;
`else
    assign result = total;
`endif

    always_comb begin
        acc_d = acc_q;
        pos_d = pos_q;
        sum_d = sum_q;
        sv_d  = sv_q;
        ov_d  = ov_q;
        if (clear) begin
            // clear wins over both a same-cycle sample and a transfer; sum keeps its value
            acc_d = '0;
            pos_d = '0;
            sv_d  = 1'b0;
            ov_d  = 1'b0;
        end else begin
            if (xfer) begin
                sv_d = 1'b0;
            end
            if (valid) begin
                if (last) begin
                    acc_d = '0;
                    pos_d = '0;
                    sum_d = result;
                    sv_d  = 1'b1;
                    // overwriting a result the consumer has not taken
                    if (sv_q && !sum_ready) begin
                        ov_d = 1'b1;
                    end
                end else begin
                    acc_d = total;
                    pos_d = pos_q + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q <= '0;
            pos_q <= '0;
            sum_q <= '0;
            sv_q  <= 1'b0;
            ov_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            pos_q <= pos_d;
            sum_q <= sum_d;
            sv_q  <= sv_d;
            ov_q  <= ov_d;
        end
    end

    assign sum       = sum_q;
    assign sum_valid = sv_q;
    assign overrun   = ov_q;
    assign frame_pos = pos_q;

endmodule

// File: doc/adder_accum.md
Name: adder_accum

Overview:
- Downstream stage of the adder block.
- Consumes the adder's registered result stream (valid_out/o) and accumulates LEN consecutive valid samples into one frame sum.
- Presents each frame sum on a valid/ready output held until consumed.
- Sits between the adder and the result-collection logic. It decouples the adder's push-only stream, which has no backpressure, from a consumer that can stall.

Parameters:
- BITS, 32, input data width; matches the adder's data width.
- LEN, 4, samples per frame; legal range 1..256.
- OUT_BITS, derived localparam BITS+$clog2(LEN) (BITS when LEN=1), accumulator and output width.

Ports:
- clk  input  1  clock
- resetn  input  1  reset
- valid  input  1  sample valid; driven by the adder's valid_out
- din  input  BITS  sample data; driven by the adder's o
- clear  input  1  synchronous flush of frame, output and flags
- sum  output  OUT_BITS  frame result
- sum_valid  output  1  frame result valid
- sum_ready  input  1  consumer accepts sum
- overrun  output  1  sticky: an unconsumed frame result was overwritten
- frame_pos  output  $clog2(LEN)+1  samples accumulated in the current frame

Behaviour:
- Reset resetn, asynchronous, active-low; clock clk.
- Reset values: sum=0, sum_valid=0, overrun=0, frame_pos=0, internal acc=0.
- Arithmetic is unsigned. din is zero-extended to OUT_BITS, so the frame sum cannot overflow.
- Input side is always ready; no input backpressure. Every cycle with valid=1 accepts din.
- Accepted sample with frame_pos<LEN-1: acc<=acc+din; frame_pos<=frame_pos+1.
- Accepted sample with frame_pos==LEN-1 (frame complete):
  - sum<=acc+din; sum_valid<=1.
  - acc<=0; frame_pos<=0.
- Latency: sum/sum_valid are visible the cycle after the last sample of a frame is accepted.
- Gaps (valid=0) between samples are allowed; the partial frame is held indefinitely.
- Output handshake: transfer occurs when sum_valid&&sum_ready. After a transfer with no same-cycle completion, sum_valid<=0 and sum keeps its value.
- sum and sum_valid are stable while sum_valid=1 and sum_ready=0, except on overrun.
- Completion while sum_valid=1 and sum_ready=0: sum is overwritten with the new frame, sum_valid stays 1, overrun<=1.
- Completion in the same cycle as a transfer: the new result is loaded, sum_valid stays 1, no overrun.
- overrun is sticky; only clear or reset lowers it.
- clear=1:
  - Next cycle: acc=0, frame_pos=0, sum_valid=0, overrun=0. sum is not cleared.
  - clear has priority over valid; a sample presented in the clear cycle is discarded.
  - clear has priority over a same-cycle transfer.
- LEN=1: every accepted sample completes a frame; behaves as a registered stage with output handshake.
- Reset mid-frame: the partial frame and pending result are lost; outputs return to reset values immediately.

Optional Feature:
- Macro ADDER_ACCUM_AVG_EN.
- Defined: sum = frame total >> $clog2(LEN), truncated. Upper $clog2(LEN) bits of sum read 0.
- Defined: LEN must be a power of two; an elaboration-time check fails otherwise.
- Undefined: sum is the raw frame total; any LEN in range is legal.
- Handshake, timing and overrun behaviour are identical in both cases.

Test Plan (BITS=32, LEN=4):
- Reset asserted mid-operation -> sum=0, sum_valid=0, overrun=0, frame_pos=0 in that cycle, without waiting for a clk edge.
- din 1,2,3,4 on consecutive valid cycles, sum_ready=1 -> sum=10 (AVG_EN: 2), sum_valid high exactly one cycle, one cycle after din=4; frame_pos sequence 1,2,3,0.
- Same samples with 2-cycle valid gaps between them -> sum=10; frame_pos holds during gaps.
- sum_ready=0; frames 1..4 then 5..8 -> after frame 1: sum=10, sum_valid=1. After frame 2: sum=26, overrun=1. Then sum_ready=1 -> one transfer of 26, overrun stays 1 until clear.
- Four samples of 0xFFFFFFFF -> sum=34'h3_FFFFFFFC (AVG_EN: 0xFFFFFFFF).
- din 1,2, clear with din=9 valid in the same cycle, then 3,4,5,6 -> sum=18; 1, 2 and 9 are excluded.
